coef_load_ctrl: RTL and testbench
=================================

Name: coef_load_ctrl

Overview:
- Sits between the SPI frame receiver (sck domain) and the biquad cascade (clk domain).
- Synchronizes the receiver's frame-valid, snapshots the 336-bit frame, and checks the sync byte.
- Waits for an audio sample boundary, then writes one stage's coefficients per cycle and applies the bypass mask, so no sample is ever processed with half-updated coefficients.

Parameters:
- NUM_STAGES, 4, number of biquad stages loaded per frame.
- COEF_W, 16, coefficient width (Q2.14).
- SYNC_BYTE, 8'hA5, required value of frame byte 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- spi_valid  in  1  frame-complete flag from the SPI receiver; asynchronous to clk.
- spi_data  in  336  frame from the receiver; static while spi_valid is high.
- sample_tick  in  1  one-cycle pulse per audio sample, clk domain.
- coef_we  out  1  coefficient write strobe.
- coef_stage  out  2  stage index for the write.
- coef_data  out  80  {b0,b1,b2,a1,a2}, with b0 in the MSBs.
- bypass_mask  out  NUM_STAGES  bit i=1 bypasses stage i.
- busy  out  1  high when state != IDLE.
- cfg_loaded  out  1  set after the first successful commit.
- frame_err  out  1  sticky; set on a bad sync byte, cleared by the next successful commit.

Behaviour:
- Reset: state=IDLE, coef_we=0, coef_stage=0, coef_data=0, bypass_mask=all ones, cfg_loaded=0, frame_err=0, pending=0, synchronizer flops=0.
- Synchronizer: 2-FF on spi_valid, then an edge flop. rise = s2 & ~s3, detected 2–3 clk after spi_valid rises.
  - System constraint: spi_valid is held high >= 3 clk periods.
  - If spi_valid is already high at reset release, this counts as a rise.
- Frame layout:
  - [335:328] sync byte.
  - [327:324] reserved, ignored.
  - [323:320] bypass mask.
  - Stage s occupies [319-80s : 240-80s].
- FSM:
  - IDLE: on rise, shadow<=spi_data, go to CHECK.
  - CHECK (1 cycle): if shadow[335:328]==SYNC_BYTE, go to WAIT_TICK. Otherwise set frame_err=1 and go to IDLE.
  - WAIT_TICK: on sample_tick, go to COMMIT with idx=0. A rise here re-captures shadow and returns to CHECK; the latest frame wins.
  - COMMIT: NUM_STAGES consecutive cycles with coef_we=1, coef_stage=idx, coef_data=stage slice, idx++.
    - All three outputs are registered, i.e. valid in the same cycle.
    - On the cycle after the last write: bypass_mask<=shadow[323:320], cfg_loaded<=1, frame_err<=0, then go to IDLE.
- Latency: the first coef_we asserts 1 cycle after the accepted sample_tick. The bypass mask changes 1 cycle after the last write.
- Boundary conditions:
  - sample_tick in IDLE or CHECK is ignored; a frame always waits for the next tick.
  - A rise during COMMIT sets pending=1. On exit to IDLE with pending=1, capture spi_data immediately, clear pending, and go to CHECK.
  - idx does not wrap; COMMIT always writes exactly NUM_STAGES stages.
  - Reset mid-COMMIT aborts the load. Partially written stages are covered by bypass_mask returning to all ones.
- coef_we is low in every state except COMMIT. coef_data holds its last value otherwise.

Optional Feature:
- CFG_FRAME_CNT_EN defined: adds outputs good_cnt[7:0] (incremented when COMMIT completes) and bad_cnt[7:0] (incremented on a sync error).
  - Both reset to 0 and wrap from 255 to 0.
  - A frame overwritten in WAIT_TICK counts in neither.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package coef_cfg_pkg holds:
  - SYNC_BYTE, COEFS_PER_STAGE=5, FRAME_BITS=16+NUM_STAGES*COEFS_PER_STAGE*COEF_W (=336).
  - The stage-offset constants.
  - State enum {IDLE, CHECK, WAIT_TICK, COMMIT}.
- Sub-module sync_pulse: 2-FF synchronizer plus rising-edge detect, with synchronous reset.

Test Plan:
- Good frame (byte0=A5, mask=4'b0010, stage s coefs=16'h1000+s*5+k); spi_valid high 10 clk; tick 20 clk later -> 4 writes on consecutive cycles, stage 0 coef_data=80'h1000_1001_1002_1003_1004; bypass_mask=0010 one cycle after the last write; cfg_loaded=1.
- Bad sync byte (byte0=5A) -> no coef_we; frame_err=1 at CHECK+1; bypass_mask stays 1111; a following good frame clears frame_err at commit.
- Two frames (b0=0x1111, then 0x2222) both arriving before any tick -> exactly one COMMIT of 4 writes, carrying 0x2222.
- New frame whose rise lands on COMMIT idx=1 -> the first commit completes; the second frame is captured on IDLE entry and commits on the next tick.
- reset asserted on COMMIT idx=2 -> next cycle: coef_we=0, bypass_mask=1111, cfg_loaded=0, busy=0.
- With CFG_FRAME_CNT_EN: 256 good frames -> good_cnt wraps to 0; one bad frame -> bad_cnt=1.

Source files
------------

// File: rtl/coef_cfg_pkg.sv
// Shared constants, frame layout and FSM state type for the coefficient loader.
// Used by coef_load_ctrl; no ports.
package coef_cfg_pkg;

    localparam int         NUM_STAGES      = 4;
    localparam int         COEF_W          = 16;
    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam int         COEFS_PER_STAGE = 5;

    localparam int STAGE_BITS = COEFS_PER_STAGE * COEF_W;
    localparam int FRAME_BITS = 16 + NUM_STAGES * STAGE_BITS;
    localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    // Frame header: sync byte, reserved nibble, bypass mask.
    localparam int SYNC_LO   = FRAME_BITS - 8;
    localparam int MASK_LO   = FRAME_BITS - 16;
    localparam int STAGE0_LO = MASK_LO - STAGE_BITS;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WAIT_TICK,
        COMMIT
    } state_t;

    // Stage 0 sits just below the header; later stages move toward bit 0.
    function automatic int stage_lo(input logic [IDX_W-1:0] s);
        return STAGE0_LO - STAGE_BITS * int'(s);
    endfunction

endpackage

// File: rtl/sync_pulse.sv
// 2-FF synchronizer followed by a rising-edge detector.
// Ports: clk, reset (sync, active-high), d (async level), rise (1-cycle pulse).
module sync_pulse (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s3 clears on reset, so a level already high at release reads as a rise.
    assign rise = s2 & ~s3;

endmodule

// File: rtl/coef_load_ctrl.sv
// Loads SPI coefficient frames into the biquad cascade on a sample boundary.
// Ports: clk, reset, spi_valid/spi_data (sck-side frame), sample_tick;
//   coef_we/coef_stage/coef_data (write port), bypass_mask, busy,
//   cfg_loaded, frame_err; good_cnt/bad_cnt when CFG_FRAME_CNT_EN is defined.
module coef_load_ctrl
    import coef_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_valid,
    input  logic [FRAME_BITS-1:0] spi_data,
    input  logic                  sample_tick,
    output logic                  coef_we,
    output logic [IDX_W-1:0]      coef_stage,
    output logic [STAGE_BITS-1:0] coef_data,
    output logic [NUM_STAGES-1:0] bypass_mask,
    output logic                  busy,
    output logic                  cfg_loaded,
    output logic                  frame_err
`ifdef CFG_FRAME_CNT_EN
    ,
    output logic [7:0]            good_cnt,
    output logic [7:0]            bad_cnt
`endif
);

    state_t                  state;
    state_t                  state_next;
    logic                    rise;
    logic [FRAME_BITS-1:0]   shadow;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic                    pending;
    logic [STAGE_BITS-1:0]   slice;

    logic sync_ok;
    logic last;
    logic capture;
    logic start;
    logic write_next;
    logic done;
    logic bad;
    logic unused_rsvd;

    sync_pulse u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_valid),
        .rise  (rise)
    );

    assign sync_ok     = shadow[SYNC_LO +: 8] == SYNC_BYTE;
    assign last        = idx == IDX_W'(NUM_STAGES - 1);
    assign unused_rsvd = ^shadow[SYNC_LO-1 : MASK_LO+NUM_STAGES];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:
                if (rise) state_next = CHECK;
            CHECK:
                state_next = sync_ok ? WAIT_TICK : IDLE;
            WAIT_TICK:
                if (rise)             state_next = CHECK;
                else if (sample_tick) state_next = COMMIT;
            COMMIT:
                if (last) state_next = (pending | rise) ? CHECK : IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    // A newer frame in WAIT_TICK replaces the shadow; one arriving during
    // COMMIT is held off until the current load has finished.
    always_comb begin
        busy       = state != IDLE;
        done       = (state == COMMIT) && last;
        bad        = (state == CHECK) && !sync_ok;
        start      = (state == WAIT_TICK) && !rise && sample_tick;
        write_next = start || ((state == COMMIT) && !last);
        capture    = ((state == IDLE) && rise)
                   || ((state == WAIT_TICK) && rise)
                   || (done && (pending | rise));
        idx_next   = start ? '0 : idx + 1'b1;
        slice      = shadow[stage_lo(idx_next) +: STAGE_BITS];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow      <= '0;
            idx         <= '0;
            pending     <= 1'b0;
            coef_we     <= 1'b0;
            coef_stage  <= '0;
            coef_data   <= '0;
            bypass_mask <= '1;
            cfg_loaded  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            coef_we <= write_next;
            if (capture) shadow <= spi_data;
            if (done)
                pending <= 1'b0;
            else if ((state == COMMIT) && rise)
                pending <= 1'b1;
            if (write_next) begin
                idx        <= idx_next;
                coef_stage <= idx_next;
                coef_data  <= slice;
            end
            if (done) begin
                bypass_mask <= shadow[MASK_LO +: NUM_STAGES];
                cfg_loaded  <= 1'b1;
                frame_err   <= 1'b0;
            end
            if (bad) frame_err <= 1'b1;
        end
    end

`ifdef CFG_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (done) good_cnt <= good_cnt + 8'd1;
            if (bad)  bad_cnt  <= bad_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Directed bench for coef_load_ctrl.
// Frames, overwrite, pending, abort, counters.
module tb_coef_load_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         spi_valid;
  logic [335:0] spi_data;
  logic         sample_tick;
  logic         coef_we;
  logic [1:0]   coef_stage;
  logic [79:0]  coef_data;
  logic [3:0]   bypass_mask;
  logic         busy;
  logic         cfg_loaded;
  logic         frame_err;
`ifdef CFG_FRAME_CNT_EN
  logic [7:0]   good_cnt;
  logic [7:0]   bad_cnt;
`endif

  int n_vec  = 0;
  int n_err  = 0;
  int we_cnt = 0;

  coef_load_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .spi_valid   (spi_valid),
    .spi_data    (spi_data),
    .sample_tick (sample_tick),
    .coef_we     (coef_we),
    .coef_stage  (coef_stage),
    .coef_data   (coef_data),
    .bypass_mask (bypass_mask),
    .busy        (busy),
    .cfg_loaded  (cfg_loaded),
    .frame_err   (frame_err)
`ifdef CFG_FRAME_CNT_EN
    ,
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (coef_we) we_cnt++;

  task automatic fail(input string tag);
    n_err++;
    $error("FAIL %s", tag);
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [335:0] mk_frame(
    input logic [7:0] sb,
    input logic [3:0] mask,
    input logic [15:0] base);
    logic [335:0] f;
    f = '0;
    f[335:328] = sb;
    f[327:324] = 4'hF;
    f[323:320] = mask;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 5; k++)
        f[319-80*s-16*k -: 16] = base + 16'(s*5+k);
    return f;
  endfunction

  function automatic logic [79:0] exp_stage(
    input logic [15:0] base,
    input int s);
    logic [79:0] r;
    r = '0;
    for (int k = 0; k < 5; k++)
      r[79-16*k -: 16] = base + 16'(s*5+k);
    return r;
  endfunction

  task automatic send(input logic [335:0] f,
                      input int hold);
    spi_data  = f;
    spi_valid = 1'b1;
    repeat (hold) step();
    spi_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_commit(input logic [15:0] base,
                           input logic [3:0] mask,
                           input logic [3:0] old_mask);
    int w0;
    w0 = we_cnt;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int s = 0; s < 4; s++) begin
      n_vec++;
      if (coef_we !== 1'b1) fail("commit_we");
      n_vec++;
      if (coef_stage !== 2'(s)) fail("commit_stage");
      n_vec++;
      if (coef_data !== exp_stage(base, s))
        fail("commit_data");
      if (s == 3) begin
        n_vec++;
        if (bypass_mask !== old_mask) fail("mask_hold");
      end
      step();
    end
    chk("done_we", coef_we, 1'b0);
    chk("done_mask", bypass_mask, mask);
    chk("done_cfg", cfg_loaded, 1'b1);
    chk("done_ferr", frame_err, 1'b0);
    chk("write_count", we_cnt - w0, 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    spi_valid   = 1'b0;
    spi_data    = '0;
    sample_tick = 1'b0;
    repeat (3) step();
    chk("rst_we", coef_we, 1'b0);
    chk("rst_stage", coef_stage, 2'd0);
    chk("rst_data", coef_data, 80'h0);
    chk("rst_mask", bypass_mask, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg", cfg_loaded, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    reset = 1'b0;
    step();

    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    chk("idle_tick_we", coef_we, 1'b0);
    chk("idle_tick_busy", busy, 1'b0);

    spi_data  = mk_frame(8'h5A, 4'b0010, 16'h1000);
    spi_valid = 1'b1;
    step();
    step();
    chk("bad_early_busy", busy, 1'b0);
    step();
    chk("bad_check_busy", busy, 1'b1);
    step();
    chk("bad_ferr", frame_err, 1'b1);
    chk("bad_busy", busy, 1'b0);
    repeat (6) step();
    spi_valid = 1'b0;
    repeat (3) step();
    chk("bad_mask", bypass_mask, 4'hF);
    chk("bad_no_we", we_cnt, 0);
    chk("bad_cfg", cfg_loaded, 1'b0);

    spi_data  = mk_frame(8'hA5, 4'b0010, 16'h1000);
    spi_valid = 1'b1;
    repeat (3) step();
    chk("good_check_busy", busy, 1'b1);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    chk("check_tick_we", coef_we, 1'b0);
    repeat (5) step();
    spi_valid = 1'b0;
    repeat (20) step();
    chk("wait_busy", busy, 1'b1);
    chk("wait_ferr", frame_err, 1'b1);
    chk("wait_we", coef_we, 1'b0);
    do_commit(16'h1000, 4'b0010, 4'hF);
    chk("good_idle", busy, 1'b0);

    send(mk_frame(8'hA5, 4'b0101, 16'h1111), 4);
    send(mk_frame(8'hA5, 4'b1000, 16'h2222), 4);
    chk("two_wait_we", coef_we, 1'b0);
    do_commit(16'h2222, 4'b1000, 4'b0010);
    step();
    chk("two_idle", busy, 1'b0);

    send(mk_frame(8'hA5, 4'b0001, 16'h3000), 4);
    spi_data    = mk_frame(8'hA5, 4'b0100, 16'h4000);
    spi_valid   = 1'b1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int s = 0; s < 4; s++) begin
      n_vec++;
      if (coef_stage !== 2'(s)) fail("pend_stage");
      n_vec++;
      if (coef_data !== exp_stage(16'h3000, s))
        fail("pend_data");
      step();
    end
    chk("pend_mask", bypass_mask, 4'b0001);
    chk("pend_we", coef_we, 1'b0);
    chk("pend_busy", busy, 1'b1);
    step();
    spi_valid = 1'b0;
    repeat (5) step();
    chk("pend_wait", busy, 1'b1);
    do_commit(16'h4000, 4'b0100, 4'b0001);

    send(mk_frame(8'hA5, 4'b0010, 16'h5000), 4);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    chk("abort_stage", coef_stage, 2'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_we", coef_we, 1'b0);
    chk("abort_mask", bypass_mask, 4'hF);
    chk("abort_cfg", cfg_loaded, 1'b0);
    chk("abort_busy", busy, 1'b0);
    step();

`ifdef CFG_FRAME_CNT_EN
    chk("cnt_rst_good", good_cnt, 8'd0);
    chk("cnt_rst_bad", bad_cnt, 8'd0);
    for (int i = 0; i < 256; i++) begin
      send(mk_frame(8'hA5, 4'b0000, 16'(i)), 3);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      repeat (5) step();
      if (i == 0) chk("cnt_good_1", good_cnt, 8'd1);
      if (i == 254)
        chk("cnt_good_255", good_cnt, 8'd255);
    end
    chk("cnt_good_wrap", good_cnt, 8'd0);
    send(mk_frame(8'h5A, 4'b0000, 16'h0), 3);
    chk("cnt_bad_1", bad_cnt, 8'd1);
    chk("cnt_good_hold", good_cnt, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
